axis_downsample: RTL and testbench

Recovers the 1-bit symbol stream from an oversampled 1-bit AXI-Stream. It is the receive-side inverse of the oversampler: it collects each group of `OVS_FACTOR` consecutive chips, decides the group's bit by majority vote, and emits one output beat per group. It sits between the oversampled chip source (generator or oversampler output) and the correlator or bit sink, and preserves packet framing through `tlast`.

---
 rtl/axis_downsample.sv | 100 ++++++++++
 tb/tb_axis_downsample.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_downsample.sv
// axis_downsample: majority-vote decimator for an oversampled 1-bit AXI-Stream.
// Each group of OVS_FACTOR chips (or fewer, when closed by tlast) yields one bit.
module axis_downsample #(
    parameter int OVS_FACTOR = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic s_axis_tdata,
    input  logic s_axis_tvalid,
    input  logic s_axis_tlast,
    output logic s_axis_tready,
    output logic m_axis_tdata,
    output logic m_axis_tvalid,
    output logic m_axis_tlast,
    input  logic m_axis_tready,
    output logic o_short_group
);

    localparam int CW = $clog2(OVS_FACTOR);
    localparam int OW = $clog2(OVS_FACTOR + 1);
    localparam int VW = OW + 2;
    localparam logic [CW-1:0] CNT_MAX = CW'(OVS_FACTOR - 1);

    logic [CW-1:0] cnt;
    logic [OW-1:0] ones;
    logic [OW-1:0] k;
    logic [VW-1:0] n_chips;
    logic [VW-1:0] k_twice;
    logic          out_data;
    logic          out_valid;
    logic          out_last;
    logic          short_q;
    logic          accept;
    logic          close;
    logic          short_close;
    logic          vote;

    // Single output register: input may advance whenever it is empty or draining.
    assign s_axis_tready = !out_valid || m_axis_tready;
    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
    assign o_short_group = short_q;

    // Group bookkeeping and the vote; a tie falls to the closing chip.
    always_comb begin
        accept      = s_axis_tvalid && s_axis_tready;
        k           = ones + OW'(s_axis_tdata);
        n_chips     = VW'(cnt) + VW'(1);
        k_twice     = VW'(k) << 1;
        close       = accept && ((cnt == CNT_MAX) || s_axis_tlast);
        short_close = close && (cnt != CNT_MAX);
        if (k_twice > n_chips) begin
            vote = 1'b1;
        end else if (k_twice < n_chips) begin
            vote = 1'b0;
        end else begin
            vote = s_axis_tdata;
        end
    end

    // Chip and ones counters; they hold while no chip is accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt  <= '0;
            ones <= '0;
        end else if (close) begin
            cnt  <= '0;
            ones <= '0;
        end else if (accept) begin
            cnt  <= cnt + CW'(1);
            ones <= k;
        end
    end

    // Output register: reload on group close, otherwise clear on handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (close) begin
            out_data  <= vote;
            out_valid <= 1'b1;
            out_last  <= s_axis_tlast;
        end else if (out_valid && m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

    // One-cycle flag for a group cut short by tlast.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            short_q <= 1'b0;
        end else begin
            short_q <= short_close;
        end
    end

endmodule

// File: tb/tb_axis_downsample.sv
// tb_axis_downsample: directed and random stimulus with a scoreboard queue
// of expected output bits checked on every output handshake.
module tb_axis_downsample;

    localparam int OVS = 4;

    logic clk = 1'b0;
    logic rst;
    logic s_tdata, s_tvalid, s_tlast, s_tready;
    logic m_tdata, m_tvalid, m_tlast, m_tready;
    logic short_grp;

    int errors = 0;
    int checks = 0;

    logic [1:0] q[$];
    int mcnt = 0;
    int mones = 0;
    logic hold_d = 1'b0;
    logic hold_l = 1'b0;

    axis_downsample #(.OVS_FACTOR(OVS)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .o_short_group (short_grp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tdata"}, m_tdata, 1'b0);
        check({tag, "_tvalid"}, m_tvalid, 1'b0);
        check({tag, "_tlast"}, m_tlast, 1'b0);
        check({tag, "_short"}, short_grp, 1'b0);
        check({tag, "_sready"}, s_tready, 1'b1);
    endtask

    // Drive one chip, wait for its handshake, then update the reference model.
    task automatic send_chip(input logic d, input logic l);
        int guard;
        int n;
        int k;
        logic bit_v;
        logic exp_short;
        guard = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("ready_timeout", s_tready, 1'b1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        n = mcnt + 1;
        k = mones + int'(d);
        exp_short = 1'b0;
        if (mcnt == OVS - 1 || l) begin
            bit_v = (2 * k > n) ? 1'b1 : (2 * k < n) ? 1'b0 : d;
            q.push_back({bit_v, l});
            hold_d = bit_v;
            hold_l = l;
            exp_short = l && (mcnt != OVS - 1);
            mcnt = 0;
            mones = 0;
            check("close_valid", m_tvalid, 1'b1);
            check("close_data", m_tdata, bit_v);
            check("close_last", m_tlast, l);
        end else begin
            mcnt = n;
            mones = k;
        end
        check("short_pulse", short_grp, exp_short);
    endtask

    task automatic send_group(input logic [3:0] g, input logic l);
        for (int i = 3; i >= 0; i--) send_chip(g[i], l && (i == 0));
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("drain_empty", q.size() == 0, 1'b1);
    endtask

    // Scoreboard: every output handshake pops and compares one expected bit.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst && m_tvalid && m_tready) begin
            if (q.size() == 0) begin
                check("extra_output", m_tvalid, 1'b0);
            end else begin
                e = q.pop_front();
                check("out_data", m_tdata, e[1]);
                check("out_last", m_tlast, e[0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        s_tdata = 1'b0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        idle(2);

        // Clean stream
        send_group(4'b1111, 1'b0);
        send_group(4'b0000, 1'b0);
        send_group(4'b1111, 1'b1);
        idle(2);
        drain();

        // Noisy votes, including ties
        send_group(4'b1101, 1'b0);
        send_group(4'b0010, 1'b0);
        send_group(4'b1100, 1'b0);
        send_group(4'b0011, 1'b0);
        idle(2);
        drain();

        // Early tlast then a fresh full group
        send_chip(1'b1, 1'b0);
        send_chip(1'b1, 1'b0);
        send_chip(1'b0, 1'b1);
        send_group(4'b0000, 1'b0);
        send_chip(1'b0, 1'b1);
        idle(2);
        drain();

        // Backpressure with a chip waiting during the stall
        m_tready = 1'b0;
        send_group(4'b1110, 1'b1);
        fork
            send_chip(1'b1, 1'b0);
            begin
                repeat (6) begin
                    @(negedge clk);
                    check("stall_sready", s_tready, 1'b0);
                    check("stall_valid", m_tvalid, 1'b1);
                    check("stall_data", m_tdata, hold_d);
                    check("stall_last", m_tlast, hold_l);
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        send_chip(1'b0, 1'b0);
        send_chip(1'b1, 1'b0);
        send_chip(1'b1, 1'b1);
        idle(2);
        drain();

        // Random valid gaps over 256 chips
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 99) < 30) idle($urandom_range(1, 2));
            send_chip(1'($urandom_range(0, 1)), i == 255);
        end
        idle(2);
        drain();

        // Asynchronous reset in the middle of a group
        send_chip(1'b0, 1'b0);
        send_chip(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_reset");
        q.delete();
        mcnt = 0;
        mones = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_group(4'b1111, 1'b0);
        idle(3);
        drain();
        check("end_idle_valid", m_tvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
